// File: rtl/dmem_pkg.sv
// Shared types and sizing helpers for the handshaked data memory (dmem_hs) and its storage array.
package dmem_pkg;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_e;

   localparam int BYTE_W = 8;
   localparam int CNT_W  = 4;

   function automatic int clog2(input int value);
      for (int r = 0; r < 32; r++) begin
         if ((1 << r) >= value) return r;
      end
      return 32;
   endfunction

   function automatic int bytes_per_word(input int data_w);
      return data_w / BYTE_W;
   endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x DATA_W storage with per-byte write enables and a registered read port; contents are never reset.
module dmem_array
   import dmem_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 1024,
   parameter int IDX_W  = 10
)
(
   input  logic                  clk,
   input  logic                  we,
   input  logic [DATA_W/8-1:0]   be,
   input  logic [IDX_W-1:0]      widx,
   input  logic [DATA_W-1:0]     wdata,
   input  logic                  re,
   input  logic [IDX_W-1:0]      ridx,
   output logic [DATA_W-1:0]     rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < DATA_W/BYTE_W; b++) begin
            if (be[b]) mem[widx][b*BYTE_W +: BYTE_W] <= wdata[b*BYTE_W +: BYTE_W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (re) rdata <= mem[ridx];
   end

endmodule

// File: rtl/dmem_hs.sv
// Handshaked data memory: one outstanding request, response after LATENCY cycles.
// Optional DMEM_MISALIGN_ERR_EN: misaligned requests are suppressed and answered with resp_err=1.
module dmem_hs
   import dmem_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 32,
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 2
)
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [ADDR_W-1:0]     req_addr,
   input  logic [DATA_W-1:0]     req_wdata,
   input  logic [DATA_W/8-1:0]   req_be,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [DATA_W-1:0]     resp_rdata,
   output logic                  resp_err
);

   localparam int BPW   = bytes_per_word(DATA_W);
   localparam int OFF_W = clog2(BPW);
   localparam int IDX_W = clog2(DEPTH);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

   dmem_state_e state, state_next;
   logic [CNT_W-1:0] cnt, cnt_next;
   logic [IDX_W-1:0] idx_q, req_idx, rd_idx;
   logic is_write_q, err_q;
   logic accept, misalign, enter_resp;
   logic [DATA_W-1:0] arr_rdata;
   logic unused_addr;

   assign req_idx     = req_addr[OFF_W +: IDX_W];
   assign unused_addr = ^req_addr;

`ifdef DMEM_MISALIGN_ERR_EN
   assign misalign = |(req_addr & ADDR_W'(BPW - 1));
`else
   assign misalign = 1'b0;
`endif

   assign accept     = req_valid & req_ready;
   assign enter_resp = (state_next == RESP) && (state != RESP);
   // With LATENCY=1 the read happens on the accept edge, so the live address is used
   assign rd_idx     = (state == IDLE) ? req_idx : idx_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         cnt        <= '0;
         idx_q      <= '0;
         is_write_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         if (accept) begin
            idx_q      <= req_idx;
            is_write_q <= req_write;
            err_q      <= misalign;
         end
      end
   end

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               cnt_next = CNT_INIT;
               if (LATENCY > 1) state_next = WAIT;
               else             state_next = RESP;
            end
         end
         WAIT: begin
            if (cnt <= CNT_W'(1)) begin
               cnt_next   = '0;
               state_next = RESP;
            end else begin
               cnt_next = cnt - CNT_W'(1);
            end
         end
         RESP: begin
            resp_valid = 1'b1;
            if (resp_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Response payload is a function of held registers only, so it stays stable while stalled
   assign resp_err   = (state == RESP) & err_q;
   assign resp_rdata = ((state == RESP) && !is_write_q && !err_q) ? arr_rdata : '0;

   dmem_array #(
      .DATA_W(DATA_W),
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) u_array (
      .clk  (clk),
      .we   (accept & req_write & ~misalign),
      .be   (req_be),
      .widx (req_idx),
      .wdata(req_wdata),
      .re   (enter_resp),
      .ridx (rd_idx),
      .rdata(arr_rdata)
   );

endmodule

// File: tb/tb_dmem_hs.sv
// Self-checking bench for dmem_hs: a LATENCY=2/DEPTH=1024 instance and a LATENCY=1/DEPTH=16 instance.
module tb_dmem_hs;

`ifdef DMEM_MISALIGN_ERR_EN
   localparam bit MIS = 1'b1;
`else
   localparam bit MIS = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, sel;
   logic req_valid, req_write, resp_ready;
   logic [31:0] req_addr, req_wdata;
   logic [3:0]  req_be;
   logic rr0, rr1, rv0, rv1, re0, re1;
   logic [31:0] rd0, rd1;
   logic req_ready, resp_valid, resp_err;
   logic [31:0] resp_rdata;

   int checks = 0;
   int errors = 0;

   logic [31:0] mem0 [1024];
   logic [31:0] mem1 [16];

   assign req_ready  = sel ? rr1 : rr0;
   assign resp_valid = sel ? rv1 : rv0;
   assign resp_err   = sel ? re1 : re0;
   assign resp_rdata = sel ? rd1 : rd0;

   dmem_hs #(.DATA_W(32), .ADDR_W(32), .DEPTH(1024), .LATENCY(2)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid & ~sel), .req_ready(rr0),
      .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .resp_valid(rv0), .resp_ready(resp_ready), .resp_rdata(rd0), .resp_err(re0)
   );

   dmem_hs #(.DATA_W(32), .ADDR_W(32), .DEPTH(16), .LATENCY(1)) dut1 (
      .clk(clk), .rst(rst), .req_valid(req_valid & sel), .req_ready(rr1),
      .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .resp_valid(rv1), .resp_ready(resp_ready), .resp_rdata(rd1), .resp_err(re1)
   );

   typedef struct {
      bit          s;
      bit          w;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      int          hold;
      logic [31:0] exp_rd;
      bit          exp_er;
   } vec_t;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference behaviour: word = (addr/4) mod DEPTH, byte-merged writes, optional misalign error
   task automatic modelTxn(input bit s, input bit w, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] be, output logic [31:0] rd, output bit er);
      int idx;
      logic [31:0] word;
      bit mis;
      mis = MIS && (a % 4 != 0);
      idx = s ? int'((a / 4) % 16) : int'((a / 4) % 1024);
      rd  = '0;
      er  = mis;
      if (!mis) begin
         word = s ? mem1[idx] : mem0[idx];
         if (w) begin
            for (int b = 0; b < 4; b++) if (be[b]) word[b*8 +: 8] = wd[b*8 +: 8];
            if (s) mem1[idx] = word; else mem0[idx] = word;
         end else begin
            rd = word;
         end
      end
   endtask

   task automatic applyStimulus(input bit s, input bit w, input logic [31:0] a, input logic [31:0] wd,
                                input logic [3:0] be, input int hold,
                                input logic [31:0] exp_rd, input bit exp_er);
      int n;
      int exp_lat;
      exp_lat = s ? 1 : 2;
      @(negedge clk);
      sel = s; req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = wd; req_be = be;
      resp_ready = (hold == 0);
      #1;
      checkOutput("req_ready_idle", req_ready, 1);
      if (req_ready !== 1'b1) begin
         req_valid = 1'b0;
         return;
      end
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      req_write = 1'($urandom); req_addr = $urandom; req_wdata = $urandom; req_be = 4'($urandom);
      checkOutput("req_ready_busy", req_ready, 0);
      n = 1;
      while (resp_valid !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      checkOutput("latency", (resp_valid === 1'b1) ? n : -1, exp_lat);
      checkOutput("rdata", resp_rdata, exp_rd);
      checkOutput("err", resp_err, exp_er);
      for (int i = 0; i < hold; i++) begin
         req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = ~wd; req_be = 4'hF;
         @(negedge clk);
         req_valid = 1'b0;
         checkOutput("hold_valid", resp_valid, 1);
         checkOutput("hold_rdata", resp_rdata, exp_rd);
         checkOutput("hold_err", resp_err, exp_er);
         checkOutput("hold_req_ready", req_ready, 0);
      end
      resp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      resp_ready = 1'b0;
      checkOutput("post_resp_valid", resp_valid, 0);
      checkOutput("post_req_ready", req_ready, 1);
   endtask

   initial begin
      vec_t vecs[12];
      logic [31:0] mrd, a, wd;
      bit mer, s, w, seen;
      int idx, lo;

      vecs[0]  = '{1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 32'h0, 1'b0};
      vecs[1]  = '{1'b0, 1'b0, 32'h10, 32'h0, 4'h0, 0, 32'hDEADBEEF, 1'b0};
      vecs[2]  = '{1'b0, 1'b1, 32'h20, 32'h11223344, 4'hF, 0, 32'h0, 1'b0};
      vecs[3]  = '{1'b0, 1'b1, 32'h20, 32'hAABBCCDD, 4'h5, 0, 32'h0, 1'b0};
      vecs[4]  = '{1'b0, 1'b0, 32'h20, 32'h0, 4'h0, 5, 32'h11BB33DD, 1'b0};
      vecs[5]  = '{1'b0, 1'b1, 32'h22, 32'h00000005, 4'hF, 0, 32'h0, MIS};
      vecs[6]  = '{1'b0, 1'b0, 32'h20, 32'h0, 4'h0, 0, MIS ? 32'h11BB33DD : 32'h00000005, 1'b0};
      vecs[7]  = '{1'b0, 1'b0, 32'h23, 32'h0, 4'h0, 0, MIS ? 32'h0 : 32'h00000005, MIS};
      vecs[8]  = '{1'b0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, 0, 32'h0, 1'b0};
      vecs[9]  = '{1'b0, 1'b0, 32'h1020, 32'h0, 4'h0, 0, MIS ? 32'h11BB33DD : 32'h00000005, 1'b0};
      vecs[10] = '{1'b1, 1'b1, 32'h00, 32'h00000001, 4'hF, 0, 32'h0, 1'b0};
      vecs[11] = '{1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 0, 32'h00000001, 1'b0};

      rst = 1'b0; sel = 1'b0; req_valid = 1'b0; req_write = 1'b0; resp_ready = 1'b0;
      req_addr = '0; req_wdata = '0; req_be = '0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         sel = 1'(i);
         #1;
         checkOutput("reset_resp_valid", resp_valid, 0);
         checkOutput("reset_rdata", resp_rdata, 0);
         checkOutput("reset_err", resp_err, 0);
      end
      sel = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      checkOutput("reset_release_ready", req_ready, 1);

      $display("[TB] directed vectors");
      for (int i = 0; i < 12; i++) begin
         applyStimulus(vecs[i].s, vecs[i].w, vecs[i].addr, vecs[i].wdata, vecs[i].be,
                       vecs[i].hold, vecs[i].exp_rd, vecs[i].exp_er);
      end

      $display("[TB] reset during WAIT");
      applyStimulus(1'b0, 1'b1, 32'h40, 32'hCAFEF00D, 4'hF, 0, 32'h0, 1'b0);
      @(negedge clk);
      sel = 1'b0; req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h40; resp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      checkOutput("wait_state_no_valid", resp_valid, 0);
      rst = 1'b0;
      #2;
      checkOutput("midreset_resp_valid", resp_valid, 0);
      checkOutput("midreset_rdata", resp_rdata, 0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      checkOutput("midreset_req_ready", req_ready, 1);
      seen = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (resp_valid !== 1'b0) seen = 1'b1;
      end
      checkOutput("discarded_read_silent", seen, 0);
      resp_ready = 1'b0;
      applyStimulus(1'b0, 1'b0, 32'h40, 32'h0, 4'h0, 0, 32'hCAFEF00D, 1'b0);

      $display("[TB] randomized traffic against model");
      for (int i = 0; i < 80; i++) begin
         s   = (i >= 64);
         a   = s ? 32'((i - 64) * 4) : 32'(i * 4);
         wd  = $urandom;
         modelTxn(s, 1'b1, a, wd, 4'hF, mrd, mer);
         applyStimulus(s, 1'b1, a, wd, 4'hF, 0, mrd, mer);
      end
      for (int i = 0; i < 200; i++) begin
         s   = 1'($urandom);
         w   = 1'($urandom);
         lo  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
         idx = s ? $urandom_range(0, 15) : $urandom_range(0, 63);
         a   = s ? (($urandom & 32'hFFFFFFC0) | 32'(idx * 4) | 32'(lo))
                 : (($urandom & 32'hFFFFF000) | 32'(idx * 4) | 32'(lo));
         wd  = $urandom;
         req_be = 4'($urandom);
         modelTxn(s, w, a, wd, req_be, mrd, mer);
         applyStimulus(s, w, a, wd, req_be, $urandom_range(0, 2), mrd, mer);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
